// File: rtl/trivium_pkg.sv
// Shared constants, tap positions and FSM encoding for the Trivium keystream core.
// Tap indices are 1-based, matching the cipher's s1..s288 notation.
package trivium_pkg;

  localparam int KEY_SZ_DEF = 80;
  localparam int IV_SZ_DEF  = 80;
  localparam int STATE_SZ   = 288;

  // Last bit of each of the three shift registers (A: 1..93, B: 94..177, C: 178..288)
  localparam int R1_END = 93;
  localparam int R2_END = 177;
  localparam int R3_END = 288;

  localparam int TAP_S66  = 66;
  localparam int TAP_S69  = 69;
  localparam int TAP_S91  = 91;
  localparam int TAP_S92  = 92;
  localparam int TAP_S93  = 93;
  localparam int TAP_S162 = 162;
  localparam int TAP_S171 = 171;
  localparam int TAP_S175 = 175;
  localparam int TAP_S176 = 176;
  localparam int TAP_S177 = 177;
  localparam int TAP_S243 = 243;
  localparam int TAP_S264 = 264;
  localparam int TAP_S286 = 286;
  localparam int TAP_S287 = 287;
  localparam int TAP_S288 = 288;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } trv_state_e;

  // Reads s_i from a vector stored with s1 at bit 0.
  function automatic logic s_at(input logic [STATE_SZ-1:0] st, input int i);
    return st[i-1];
  endfunction

endpackage

// File: rtl/trivium_update.sv
// One Trivium state update: combinational next state and output bit z.
module trivium_update
  import trivium_pkg::*;
(
  input  logic [STATE_SZ-1:0] st,
  output logic [STATE_SZ-1:0] st_nxt,
  output logic                z
);

  logic t1, t2, t3;
  logic t1_fb, t2_fb, t3_fb;

  always_comb begin
    t1 = s_at(st, TAP_S66)  ^ s_at(st, TAP_S93);
    t2 = s_at(st, TAP_S162) ^ s_at(st, TAP_S177);
    t3 = s_at(st, TAP_S243) ^ s_at(st, TAP_S288);
    z  = t1 ^ t2 ^ t3;

    t1_fb = t1 ^ (s_at(st, TAP_S91)  & s_at(st, TAP_S92))  ^ s_at(st, TAP_S171);
    t2_fb = t2 ^ (s_at(st, TAP_S175) & s_at(st, TAP_S176)) ^ s_at(st, TAP_S264);
    t3_fb = t3 ^ (s_at(st, TAP_S286) & s_at(st, TAP_S287)) ^ s_at(st, TAP_S69);

    // Each register shifts toward higher indices; the cross feedback enters at its head.
    st_nxt                  = st;
    st_nxt[R1_END-1:0]      = {st[R1_END-2:0], t3_fb};
    st_nxt[R2_END-1:R1_END] = {st[R2_END-2:R1_END], t1_fb};
    st_nxt[R3_END-1:R2_END] = {st[R3_END-2:R2_END], t2_fb};
  end

endmodule

// File: rtl/trivium_keystream_core.sv
// Trivium keystream core: key/IV load, warm-up, then one bit per transfer on a valid/ready port.
// Optional macro TRIVIUM_KS_COUNT_EN adds ks_cnt_o, a saturating count of accepted bits.
module trivium_keystream_core
  import trivium_pkg::*;
#(
  parameter int KEY_SZ        = KEY_SZ_DEF,
  parameter int IV_SZ         = IV_SZ_DEF,
  parameter int WARMUP_CYCLES = 4 * STATE_SZ
) (
  input  logic              clk_i,
  input  logic              n_rst_i,
  input  logic              ce_i,
  input  logic [KEY_SZ-1:0] key_i,
  input  logic [IV_SZ-1:0]  iv_i,
  input  logic              start_i,
  input  logic              stop_i,
  output logic              busy_o,
  output logic              ks_valid_o,
`ifdef TRIVIUM_KS_COUNT_EN
  output logic [31:0]       ks_cnt_o,
`endif
  input  logic              ks_ready_i,
  output logic              ks_o
);

  localparam int CNT_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WARM_INIT = CNT_W'(WARMUP_CYCLES - 1);

  trv_state_e          state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [STATE_SZ-1:0] st, st_nxt, st_upd, st_load;
  logic                z;

  trivium_update u_update (
    .st     (st),
    .st_nxt (st_upd),
    .z      (z)
  );

  always_comb begin
    st_load                          = '0;
    st_load[KEY_SZ-1:0]              = key_i;
    st_load[R1_END+IV_SZ-1:R1_END]   = iv_i;
    st_load[STATE_SZ-1:STATE_SZ-3]   = 3'b111;
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
      st    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      st    <= st_nxt;
    end
  end

  // start_i beats stop_i, and stop_i beats any pending advance.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    st_nxt    = st;
    if (ce_i) begin
      if (start_i) begin
        st_nxt    = st_load;
        cnt_nxt   = WARM_INIT;
        state_nxt = ST_WARMUP;
      end else if (stop_i) begin
        state_nxt = ST_IDLE;
      end else begin
        case (state)
          ST_WARMUP: begin
            st_nxt = st_upd;
            if (cnt == '0) state_nxt = ST_RUN;
            else           cnt_nxt   = cnt - CNT_W'(1);
          end
          ST_RUN: begin
            if (ks_ready_i) st_nxt = st_upd;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy_o     = (state != ST_IDLE);
  assign ks_valid_o = (state == ST_RUN);
  assign ks_o       = ks_valid_o & z;

`ifdef TRIVIUM_KS_COUNT_EN
  logic [31:0] ks_cnt;
  logic        xfer;

  assign xfer = ce_i & ks_valid_o & ks_ready_i & ~start_i & ~stop_i;

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i)                         ks_cnt <= '0;
    else if (ce_i && start_i)             ks_cnt <= '0;
    else if (xfer && (ks_cnt != '1))      ks_cnt <= ks_cnt + 32'd1;
  end

  assign ks_cnt_o = ks_cnt;
`endif

endmodule

// File: tb/tb_trivium_keystream_core.sv
// Randomized bench for trivium_keystream_core against a bit-level reference of the cipher.
// Build with TRIVIUM_KS_COUNT_EN defined to also exercise the transfer counter.
module tb_trivium_keystream_core;

  logic        clk_i = 1'b0;
  logic        n_rst_i;
  logic        ce_i;
  logic [79:0] key_i;
  logic [79:0] iv_i;
  logic        start_i;
  logic        stop_i;
  logic        busy_o;
  logic        ks_valid_o;
  logic        ks_ready_i;
  logic        ks_o;
`ifdef TRIVIUM_KS_COUNT_EN
  logic [31:0] ks_cnt_o;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  bit exp_q[$];

  always #5 clk_i = ~clk_i;

  trivium_keystream_core dut (
    .clk_i      (clk_i),
    .n_rst_i    (n_rst_i),
    .ce_i       (ce_i),
    .key_i      (key_i),
    .iv_i       (iv_i),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .busy_o     (busy_o),
    .ks_valid_o (ks_valid_o),
`ifdef TRIVIUM_KS_COUNT_EN
    .ks_cnt_o   (ks_cnt_o),
`endif
    .ks_ready_i (ks_ready_i),
    .ks_o       (ks_o)
  );

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [79:0] rand80();
    return {16'($urandom), $urandom(), $urandom()};
  endfunction

  // Reference cipher written directly over s[1..288]; fills exp_q with n keystream bits.
  task automatic model_gen(input logic [79:0] key, input logic [79:0] iv, input int n);
    bit s[1:288];
    bit t1, t2, t3;
    exp_q.delete();
    for (int i = 1; i <= 288; i++) s[i] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      s[i]      = key[i-1];
      s[93 + i] = iv[i-1];
    end
    s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
    for (int i = 0; i < 1152 + n; i++) begin
      t1 = s[66] ^ s[93];
      t2 = s[162] ^ s[177];
      t3 = s[243] ^ s[288];
      if (i >= 1152) exp_q.push_back(t1 ^ t2 ^ t3);
      t1 = t1 ^ (s[91] & s[92]) ^ s[171];
      t2 = t2 ^ (s[175] & s[176]) ^ s[264];
      t3 = t3 ^ (s[286] & s[287]) ^ s[69];
      for (int j = 93; j >= 2; j--) s[j] = s[j-1];
      s[1] = t3;
      for (int j = 177; j >= 95; j--) s[j] = s[j-1];
      s[94] = t1;
      for (int j = 288; j >= 179; j--) s[j] = s[j-1];
      s[178] = t2;
    end
  endtask

  // Load, measure first-valid latency, then collect and compare nbits keystream bits.
  task automatic run_seq(input string tag, input logic [79:0] key, input logic [79:0] iv,
                         input int nbits, input bit rnd_rdy, input int ce_warm_at,
                         input int ce_run_at, input bit with_stop);
    int  cyc, rc, idx, exp_lat;
    bit  held, prev_ks;
    model_gen(key, iv, nbits);
    exp_lat = 1153 + ((ce_warm_at > 0) ? 10 : 0);
    key_i = key; iv_i = iv; start_i = 1'b1; stop_i = with_stop;
    ce_i = 1'b1; ks_ready_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; stop_i = 1'b0;
    key_i = rand80(); iv_i = rand80();
    cyc = 1;
    while (!ks_valid_o && cyc < 1400) begin
      ce_i = !(ce_warm_at > 0 && cyc >= ce_warm_at && cyc < ce_warm_at + 10);
      @(negedge clk_i);
      cyc++;
    end
    ce_i = 1'b1;
    chk_val({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    held = 1'b0; prev_ks = 1'b0; rc = 0; idx = 0;
    while (idx < nbits && rc < nbits * 4 + 200) begin
      if (held) chk_val({tag, "_hold"}, 64'({ks_valid_o, ks_o}), 64'({1'b1, prev_ks}));
      ce_i = !(ce_run_at > 0 && rc >= ce_run_at && rc < ce_run_at + 10);
      ks_ready_i = rnd_rdy ? 1'($urandom & 1) : 1'b1;
      if (ce_i && ks_ready_i) begin
        chk_val({tag, "_bit"}, 64'({ks_valid_o, ks_o}), 64'({1'b1, exp_q[idx]}));
        idx++;
        held = 1'b0;
      end else begin
        held = 1'b1;
        prev_ks = ks_o;
      end
      @(negedge clk_i);
      rc++;
    end
    ce_i = 1'b1;
    ks_ready_i = 1'b0;
    chk_val({tag, "_count"}, 64'(idx), 64'(nbits));
  endtask

  initial begin
    n_rst_i = 1'b0; ce_i = 1'b1; key_i = '0; iv_i = '0;
    start_i = 1'b0; stop_i = 1'b0; ks_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk_val("in_reset", 64'({busy_o, ks_valid_o, ks_o}), 64'(0));
    n_rst_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      key_i = rand80(); iv_i = rand80(); ks_ready_i = 1'($urandom & 1);
      @(negedge clk_i);
      chk_val("idle", 64'({busy_o, ks_valid_o, ks_o}), 64'(0));
    end

    run_seq("zero", 80'h0, 80'h0, 256, 1'b0, 0, 0, 1'b0);
    run_seq("vec", 80'h0123_4567_89AB_CDEF_0123, 80'hFFFF_0000_FFFF_0000_FFFF,
            1024, 1'b0, 0, 0, 1'b0);
    run_seq("vec_rdy", 80'h0123_4567_89AB_CDEF_0123, 80'hFFFF_0000_FFFF_0000_FFFF,
            1024, 1'b1, 0, 0, 1'b0);
    run_seq("ce_gap", rand80(), rand80(), 200, 1'b1, 500, 30, 1'b0);

    // Restart at bit 40 with a fresh key
    run_seq("pre_restart", rand80(), rand80(), 40, 1'b0, 0, 0, 1'b0);
    run_seq("restart", rand80(), rand80(), 100, 1'b1, 0, 0, 1'b0);

    // Abort during warm-up
    key_i = rand80(); iv_i = rand80(); start_i = 1'b1; ks_ready_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (20) @(negedge clk_i);
    chk_val("warm_busy", 64'({busy_o, ks_valid_o}), 64'(2'b10));
    stop_i = 1'b1;
    @(negedge clk_i);
    stop_i = 1'b0;
    chk_val("stop_idle", 64'({busy_o, ks_valid_o}), 64'(0));
    repeat (1200) @(negedge clk_i);
    chk_val("stop_stays", 64'({busy_o, ks_valid_o, ks_o}), 64'(0));

    // start_i and stop_i together: start wins
    run_seq("start_stop", rand80(), rand80(), 64, 1'b1, 0, 0, 1'b1);

`ifdef TRIVIUM_KS_COUNT_EN
    run_seq("cnt", rand80(), rand80(), 300, 1'b1, 0, 0, 1'b0);
    chk_val("cnt_300", 64'(ks_cnt_o), 64'(300));
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    chk_val("cnt_clear", 64'(ks_cnt_o), 64'(0));
    for (int i = 0; i < 1400 && !ks_valid_o; i++) @(negedge clk_i);
    force dut.ks_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.ks_cnt;
    ks_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    ks_ready_i = 1'b0;
    chk_val("cnt_sat", 64'(ks_cnt_o), 64'(32'hFFFF_FFFF));
`endif

    // Asynchronous reset mid-stream
    run_seq("pre_reset", rand80(), rand80(), 20, 1'b0, 0, 0, 1'b0);
    ks_ready_i = 1'b1;
    n_rst_i = 1'b0;
    #1;
    chk_val("async_reset", 64'({busy_o, ks_valid_o, ks_o}), 64'(0));
    @(negedge clk_i);
    n_rst_i = 1'b1;
    @(negedge clk_i);
    chk_val("post_reset", 64'({busy_o, ks_valid_o, ks_o}), 64'(0));
    run_seq("recover", rand80(), rand80(), 32, 1'b0, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/trivium_keystream_core.md
Name: trivium_keystream_core

Overview:
- Trivium cipher core that sits directly downstream of the serial key/IV shift registers.
- Takes the parallel 80-bit key and 80-bit IV and loads the 288-bit Trivium state.
- Runs the warm-up rounds, then emits one keystream bit per cycle under a valid/ready handshake to the encrypt/output stage.

Parameters:
- KEY_SZ, 80, key width in bits (fixed by the algorithm; only 80 is supported).
- IV_SZ, 80, IV width in bits (fixed by the algorithm; only 80 is supported).
- WARMUP_CYCLES, 1152, number of state updates before the first keystream bit (4 x 288). Must be >= 1.

Ports:
- clk_i  in  1  system clock.
- n_rst_i  in  1  asynchronous reset, active low.
- ce_i  in  1  chip enable; when 0, all state, counters and the FSM hold.
- key_i  in  KEY_SZ  key; bit 0 is K1.
- iv_i  in  IV_SZ  IV; bit 0 is IV1.
- start_i  in  1  single-cycle load/restart request.
- stop_i  in  1  abort; return to IDLE.
- busy_o  out  1  high in LOAD, WARMUP and RUN.
- ks_valid_o  out  1  keystream bit valid (RUN only).
- ks_o  out  1  keystream bit z.
- ks_ready_i  in  1  consumer accepts ks_o.

Behaviour:
- Reset: state register s[1..288] = 0, FSM = IDLE, warm-up counter = 0, busy_o = 0, ks_valid_o = 0, ks_o = 0.
- Nothing advances while ce_i = 0; outputs hold their last values.
- FSM states: IDLE, WARMUP, RUN. The LOAD action happens on the transition into WARMUP.
- IDLE -> WARMUP on start_i:
  - s[1..80] = key_i[0..79], s[81..93] = 0.
  - s[94..173] = iv_i[0..79], s[174..177] = 0.
  - s[178..285] = 0, s[286..288] = 1.
  - Counter loaded with WARMUP_CYCLES - 1.
  - busy_o = 1 from the next cycle.
- Update function, applied on every advance:
  - t1 = s66^s93, t2 = s162^s177, t3 = s243^s288.
  - z = t1^t2^t3.
  - t1 ^= (s91&s92)^s171; t2 ^= (s175&s176)^s264; t3 ^= (s286&s287)^s69.
  - Shift: s[1..93] = {t3, s1..s92}; s[94..177] = {t1, s94..s176}; s[178..288] = {t2, s178..s287}.
- WARMUP:
  - Advance every enabled cycle; decrement the counter.
  - At counter = 0 (WARMUP_CYCLES updates done), go to RUN.
  - ks_valid_o = 0 throughout.
- RUN:
  - ks_valid_o = 1; ks_o = z, computed combinationally from the current state.
  - The state advances only when ks_valid_o & ks_ready_i (transfer).
  - With ks_ready_i = 0, ks_o is stable.
- Latency:
  - First ks_valid_o is asserted WARMUP_CYCLES + 1 enabled cycles after the start_i cycle.
  - Thereafter one bit per cycle at full throughput.
- stop_i in any state -> IDLE. ks_valid_o and busy_o drop next cycle; the state register is retained (not cleared).
- start_i in WARMUP or RUN: reload and restart warm-up (restart). start_i and stop_i in the same cycle: start_i wins.
- key_i/iv_i are sampled only in the start_i cycle; later changes have no effect.
- Reset mid-operation: immediate return to reset values; no partial keystream.

Optional Feature:
- Macro TRIVIUM_KS_COUNT_EN.
- Defined:
  - Adds output ks_cnt_o [31:0].
  - Counts accepted keystream bits (transfers) since the last start_i.
  - Cleared to 0 on start_i and on reset; saturates at 32'hFFFF_FFFF; holds in IDLE.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package trivium_pkg:
  - KEY_SZ/IV_SZ defaults and STATE_SZ = 288.
  - Register boundaries 93/177/288.
  - Tap indices (66, 69, 91, 92, 93, 162, 171, 175, 176, 177, 243, 264, 286, 287, 288).
  - FSM state encoding typedef.
- One sub-module, trivium_update: purely combinational. Takes the 288-bit state, returns the next state and z.
- FSM, counter and handshake stay in the top level.

Test Plan:
- Reset then idle: after deassertion, busy_o = 0, ks_valid_o = 0, ks_o = 0; start_i held low for 100 cycles -> no change.
- key = 80'h0, iv = 80'h0, start_i pulse, ks_ready_i = 1 -> ks_valid_o rises exactly 1153 cycles after start_i. The first 256 bits match the bit-level Python golden model for the same inputs.
- key = 80'h0123_4567_89AB_CDEF_0123, iv = 80'hFFFF_0000_FFFF_0000_FFFF -> 1024 bits match the golden model. Random ks_ready_i (50%) gives an identical bit sequence, and ks_o stays stable while ready = 0.
- ce_i toggled low for 10 cycles at warm-up cycle 500 and during RUN -> first valid is delayed by exactly 10 cycles; the sequence is unchanged.
- start_i reasserted at RUN bit 40 with a new key -> ks_valid_o = 0 for 1152 cycles, then the new key's sequence from bit 0. stop_i in WARMUP -> IDLE next cycle. start_i + stop_i together -> restart.
- With TRIVIUM_KS_COUNT_EN: 300 transfers -> ks_cnt_o = 300; start_i clears it to 0. Saturation checked by forcing the counter to 32'hFFFF_FFFE and performing 3 transfers -> 32'hFFFF_FFFF.
